// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU control decode and EX forwarding.
// Drives ALU operands combinationally from stored fields and forward muxes.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int FWD_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_rs_val,
  input  logic [DATA_W-1:0] id_rt_val,
  input  logic [15:0]       id_imm,
  input  logic              id_zext,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [1:0]        id_alu_op,
  input  logic [5:0]        id_funct,
  input  logic              id_alu_src,
  input  logic              id_reg_dst,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_mem_to_reg,
  input  logic [1:0]        fwd_a_sel,
  input  logic [1:0]        fwd_b_sel,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic [DATA_W-1:0] memwb_result,
  output logic              ex_valid,
  output logic [3:0]        alu_ctl,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [REG_AW-1:0] ex_dest,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg,
  output logic              ex_illegal
);

  localparam logic [3:0] CTL_AND = 4'b0000;
  localparam logic [3:0] CTL_OR  = 4'b0001;
  localparam logic [3:0] CTL_ADD = 4'b0010;
  localparam logic [3:0] CTL_SUB = 4'b0110;
  localparam logic [3:0] CTL_SLT = 4'b0111;
  localparam logic [3:0] CTL_NOR = 4'b1100;
  localparam logic [3:0] CTL_BAD = 4'b1111;

  logic [DATA_W-1:0] imm_ext;
  logic [REG_AW-1:0] dest;
  logic [3:0]        ctl;
  logic              bad;

  logic [DATA_W-1:0] rs_q;
  logic [DATA_W-1:0] rt_q;
  logic [DATA_W-1:0] imm_q;
  logic              src_q;

  logic [1:0]        sel_a;
  logic [1:0]        sel_b;
  logic [DATA_W-1:0] rt_f;

  // ID-side resolve: extend imm, pick dest, decode ALU control
  always_comb begin
    imm_ext = {{(DATA_W-16){id_imm[15] & ~id_zext}}, id_imm};
    dest    = id_reg_dst ? id_rd : id_rt;
    ctl     = CTL_ADD;
    bad     = 1'b0;
    case (id_alu_op)
      2'b00: ctl = CTL_ADD;
      2'b01: ctl = CTL_SUB;
      2'b11: ctl = CTL_OR;
      default: begin
        case (id_funct)
          6'b100000: ctl = CTL_ADD;
          6'b100010: ctl = CTL_SUB;
          6'b100100: ctl = CTL_AND;
          6'b100101: ctl = CTL_OR;
          6'b101010: ctl = CTL_SLT;
          6'b100111: ctl = CTL_NOR;
          default: begin
            ctl = CTL_BAD;
            bad = 1'b1;
          end
        endcase
      end
    endcase
  end

  // Pipeline register: reset/flush bubble, stall hold, else load
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      ex_valid      <= 1'b0;
      alu_ctl       <= CTL_ADD;
      ex_illegal    <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_dest       <= '0;
      rs_q          <= '0;
      rt_q          <= '0;
      imm_q         <= '0;
      src_q         <= 1'b0;
    end else if (!stall) begin
      ex_valid      <= id_valid;
      alu_ctl       <= id_valid ? ctl : CTL_ADD;
      ex_illegal    <= id_valid & bad;
      ex_reg_write  <= id_valid & id_reg_write & ~bad;
      ex_mem_read   <= id_valid & id_mem_read;
      ex_mem_write  <= id_valid & id_mem_write & ~bad;
      ex_mem_to_reg <= id_valid & id_mem_to_reg;
      ex_dest       <= dest;
      rs_q          <= id_rs_val;
      rt_q          <= id_rt_val;
      imm_q         <= imm_ext;
      src_q         <= id_alu_src;
    end
  end

  // EX forwarding muxes; FWD_EN=0 pins both selects to the register path
  always_comb begin
    sel_a = (FWD_EN != 0) ? fwd_a_sel : 2'b00;
    sel_b = (FWD_EN != 0) ? fwd_b_sel : 2'b00;
    case (sel_a)
      2'b10:   alu_a = exmem_result;
      2'b01:   alu_a = memwb_result;
      default: alu_a = rs_q;
    endcase
    case (sel_b)
      2'b10:   rt_f = exmem_result;
      2'b01:   rt_f = memwb_result;
      default: rt_f = rt_q;
    endcase
    alu_b         = src_q ? imm_q : rt_f;
    ex_store_data = rt_f;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage.
// Expected EX state is queued with each ID drive and popped after the edge.
module tb_id_ex_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        id_valid;
  logic [31:0] id_rs_val;
  logic [31:0] id_rt_val;
  logic [15:0] id_imm;
  logic        id_zext;
  logic [4:0]  id_rt;
  logic [4:0]  id_rd;
  logic [1:0]  id_alu_op;
  logic [5:0]  id_funct;
  logic        id_alu_src;
  logic        id_reg_dst;
  logic        id_reg_write;
  logic        id_mem_read;
  logic        id_mem_write;
  logic        id_mem_to_reg;
  logic [1:0]  fwd_a_sel;
  logic [1:0]  fwd_b_sel;
  logic [31:0] exmem_result;
  logic [31:0] memwb_result;

  logic        ex_valid;
  logic [3:0]  alu_ctl;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_dest;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_mem_to_reg;
  logic        ex_illegal;

  logic        n_valid;
  logic [3:0]  n_ctl;
  logic [31:0] n_a;
  logic [31:0] n_b;
  logic [31:0] n_sd;
  logic [4:0]  n_dest;
  logic        n_rw;
  logic        n_mr;
  logic        n_mw;
  logic        n_mtr;
  logic        n_ill;

  typedef struct packed {
    logic        v;
    logic [3:0]  ctl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sd;
    logic [4:0]  dest;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        mtr;
    logic        ill;
  } ex_t;

  ex_t sb[$];
  ex_t e;
  ex_t o;
  int  checks;
  int  failures;

  id_ex_stage #(.DATA_W(32), .REG_AW(5), .FWD_EN(1)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_rs_val(id_rs_val),
    .id_rt_val(id_rt_val), .id_imm(id_imm),
    .id_zext(id_zext), .id_rt(id_rt), .id_rd(id_rd),
    .id_alu_op(id_alu_op), .id_funct(id_funct),
    .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write),
    .id_mem_to_reg(id_mem_to_reg),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .exmem_result(exmem_result),
    .memwb_result(memwb_result),
    .ex_valid(ex_valid), .alu_ctl(alu_ctl),
    .alu_a(alu_a), .alu_b(alu_b),
    .ex_store_data(ex_store_data), .ex_dest(ex_dest),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg),
    .ex_illegal(ex_illegal)
  );

  id_ex_stage #(.DATA_W(32), .REG_AW(5), .FWD_EN(0)) nofwd (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_rs_val(id_rs_val),
    .id_rt_val(id_rt_val), .id_imm(id_imm),
    .id_zext(id_zext), .id_rt(id_rt), .id_rd(id_rd),
    .id_alu_op(id_alu_op), .id_funct(id_funct),
    .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write),
    .id_mem_to_reg(id_mem_to_reg),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .exmem_result(exmem_result),
    .memwb_result(memwb_result),
    .ex_valid(n_valid), .alu_ctl(n_ctl),
    .alu_a(n_a), .alu_b(n_b),
    .ex_store_data(n_sd), .ex_dest(n_dest),
    .ex_reg_write(n_rw), .ex_mem_read(n_mr),
    .ex_mem_write(n_mw), .ex_mem_to_reg(n_mtr),
    .ex_illegal(n_ill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ex_t mk(
    input logic v, input logic [3:0] ctl,
    input logic [31:0] a, input logic [31:0] b,
    input logic [31:0] sd, input logic [4:0] dest,
    input logic rw, input logic mr,
    input logic mw, input logic mtr, input logic ill
  );
    ex_t r;
    r = '{v, ctl, a, b, sd, dest, rw, mr, mw, mtr, ill};
    return r;
  endfunction

  function automatic ex_t obs();
    ex_t r;
    r = '{ex_valid, alu_ctl, alu_a, alu_b, ex_store_data,
          ex_dest, ex_reg_write, ex_mem_read, ex_mem_write,
          ex_mem_to_reg, ex_illegal};
    return r;
  endfunction

  task automatic clear_id();
    stall = 0; flush = 0; id_valid = 0;
    id_rs_val = 0; id_rt_val = 0; id_imm = 0;
    id_zext = 0; id_rt = 0; id_rd = 0;
    id_alu_op = 0; id_funct = 0; id_alu_src = 0;
    id_reg_dst = 0; id_reg_write = 0; id_mem_read = 0;
    id_mem_write = 0; id_mem_to_reg = 0;
    fwd_a_sel = 0; fwd_b_sel = 0;
    exmem_result = 0; memwb_result = 0;
  endtask

  task automatic test_reset();
    clear_id();
    id_valid = 1; id_rs_val = $urandom; id_rt_val = $urandom;
    id_rd = 5'd17; id_reg_dst = 1; id_alu_op = 2'b10;
    id_funct = 6'b100010; id_reg_write = 1; id_mem_read = 1;
    @(posedge clk); #1;
    rst = 1;
    id_rs_val = $urandom; id_rt_val = $urandom;
    sb.push_back(mk(0, 4'b0010, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    rst = 0;
    e = sb.pop_front(); o = obs(); checks++;
    if (o !== e) begin
      failures++;
      $display("FAIL reset got=%h exp=%h", o, e);
    end
  endtask

  task automatic test_rtype();
    logic [5:0] fn [6];
    logic [3:0] cc [6];
    logic [31:0] rs, rt;
    fn = '{6'b100000, 6'b100010, 6'b100100,
           6'b100101, 6'b101010, 6'b100111};
    cc = '{4'b0010, 4'b0110, 4'b0000,
           4'b0001, 4'b0111, 4'b1100};
    clear_id();
    id_valid = 1; id_rs_val = 7; id_rt_val = 3;
    id_funct = 6'b100010; id_alu_op = 2'b10;
    id_reg_dst = 1; id_rd = 9; id_rt = 4; id_reg_write = 1;
    sb.push_back(mk(1, 4'b0110, 7, 3, 3, 9, 1, 0, 0, 0, 0));
    @(posedge clk); #1;
    e = sb.pop_front(); o = obs(); checks++;
    if (o !== e) begin
      failures++;
      $display("FAIL rtype_sub got=%h exp=%h", o, e);
    end
    for (int i = 0; i < 6; i++) begin
      rs = $urandom; rt = $urandom;
      id_rs_val = rs; id_rt_val = rt; id_funct = fn[i];
      id_rd = 5'(i + 1);
      sb.push_back(mk(1, cc[i], rs, rt, rt, 5'(i + 1),
                      1, 0, 0, 0, 0));
      @(posedge clk); #1;
      e = sb.pop_front(); o = obs(); checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL rtype_funct%0d got=%h exp=%h", i, o, e);
      end
    end
  endtask

  task automatic test_imm();
    clear_id();
    id_valid = 1; id_rs_val = 10; id_rt_val = 5;
    id_imm = 16'hFFFC; id_zext = 0; id_alu_src = 1;
    id_rt = 8; id_rd = 30; id_alu_op = 2'b00; id_reg_write = 1;
    sb.push_back(mk(1, 4'b0010, 10, 32'hFFFFFFFC, 5, 8,
                    1, 0, 0, 0, 0));
    @(posedge clk); #1;
    e = sb.pop_front(); o = obs(); checks++;
    if (o !== e) begin
      failures++;
      $display("FAIL addi got=%h exp=%h", o, e);
    end
    id_imm = 16'h8000; id_zext = 1; id_alu_op = 2'b11;
    sb.push_back(mk(1, 4'b0001, 10, 32'h00008000, 5, 8,
                    1, 0, 0, 0, 0));
    @(posedge clk); #1;
    e = sb.pop_front(); o = obs(); checks++;
    if (o !== e) begin
      failures++;
      $display("FAIL ori got=%h exp=%h", o, e);
    end
    id_imm = 16'h0123; id_zext = 0; id_alu_op = 2'b01;
    id_reg_write = 0; id_mem_read = 1; id_mem_to_reg = 1;
    sb.push_back(mk(1, 4'b0110, 10, 32'h00000123, 5, 8,
                    0, 1, 0, 1, 0));
    @(posedge clk); #1;
    e = sb.pop_front(); o = obs(); checks++;
    if (o !== e) begin
      failures++;
      $display("FAIL sub_imm got=%h exp=%h", o, e);
    end
  endtask

  task automatic test_forward();
    clear_id();
    id_valid = 1; id_rs_val = 1; id_rt_val = 2;
    id_alu_op = 2'b00; id_rt = 3;
    exmem_result = 32'hDEAD0000; memwb_result = 32'hCAFEBABE;
    fwd_a_sel = 2'b10;
    sb.push_back(mk(1, 4'b0010, 32'hDEAD0000, 2, 2, 3,
                    0, 0, 0, 0, 0));
    @(posedge clk); #1;
    e = sb.pop_front(); o = obs(); checks++;
    if (o !== e) begin
      failures++;
      $display("FAIL fwd_a_exmem got=%h exp=%h", o, e);
    end
    fwd_a_sel = 2'b11; fwd_b_sel = 2'b01;
    id_alu_src = 1; id_imm = 16'h0004; id_mem_write = 1;
    sb.push_back(mk(1, 4'b0010, 1, 4, 32'hCAFEBABE, 3,
                    0, 0, 1, 0, 0));
    @(posedge clk); #1;
    e = sb.pop_front(); o = obs(); checks++;
    if (o !== e) begin
      failures++;
      $display("FAIL fwd_b_memwb got=%h exp=%h", o, e);
    end
    fwd_a_sel = 2'b01; fwd_b_sel = 2'b10;
    id_alu_src = 0; id_mem_write = 0;
    sb.push_back(mk(1, 4'b0010, 32'hCAFEBABE, 32'hDEAD0000,
                    32'hDEAD0000, 3, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    e = sb.pop_front(); o = obs(); checks++;
    if (o !== e) begin
      failures++;
      $display("FAIL fwd_mix got=%h exp=%h", o, e);
    end
    // forward muxes stay live while the register holds
    stall = 1;
    exmem_result = 32'h12345678;
    sb.push_back(mk(1, 4'b0010, 32'hCAFEBABE, 32'h12345678,
                    32'h12345678, 3, 0, 0, 0, 0, 0));
    #1;
    e = sb.pop_front(); o = obs(); checks++;
    if (o !== e) begin
      failures++;
      $display("FAIL fwd_live got=%h exp=%h", o, e);
    end
    stall = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_fwd_disabled();
    clear_id();
    id_valid = 1; id_rs_val = 11; id_rt_val = 22;
    exmem_result = 32'hAAAA5555; memwb_result = 32'h5555AAAA;
    fwd_a_sel = 2'b10; fwd_b_sel = 2'b01;
    @(posedge clk); #1;
    checks++;
    if (n_a !== 32'd11) begin
      failures++;
      $display("FAIL nofwd_a got=%h exp=%h", n_a, 32'd11);
    end
    checks++;
    if (n_b !== 32'd22) begin
      failures++;
      $display("FAIL nofwd_b got=%h exp=%h", n_b, 32'd22);
    end
    checks++;
    if (n_sd !== 32'd22) begin
      failures++;
      $display("FAIL nofwd_sd got=%h exp=%h", n_sd, 32'd22);
    end
  endtask

  task automatic test_stall();
    ex_t held;
    clear_id();
    id_valid = 1; id_rs_val = 32'h100; id_rt_val = 32'h200;
    id_alu_op = 2'b10; id_funct = 6'b100101;
    id_reg_dst = 1; id_rd = 12; id_reg_write = 1;
    held = mk(1, 4'b0001, 32'h100, 32'h200, 32'h200, 12,
              1, 0, 0, 0, 0);
    sb.push_back(held);
    @(posedge clk); #1;
    e = sb.pop_front(); o = obs(); checks++;
    if (o !== e) begin
      failures++;
      $display("FAIL stall_load got=%h exp=%h", o, e);
    end
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      id_rs_val = $urandom; id_rt_val = $urandom;
      id_rd = 5'($urandom); id_funct = 6'b100010;
      id_mem_write = 1; id_valid = 1'($urandom);
      sb.push_back(held);
      @(posedge clk); #1;
      e = sb.pop_front(); o = obs(); checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL stall_hold%0d got=%h exp=%h", i, o, e);
      end
    end
    flush = 1;
    sb.push_back(mk(0, 4'b0010, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    e = sb.pop_front(); o = obs(); checks++;
    if (o !== e) begin
      failures++;
      $display("FAIL stall_flush got=%h exp=%h", o, e);
    end
    stall = 0; flush = 0;
    id_valid = 1; id_rs_val = 32'h77; id_rt_val = 32'h88;
    id_rd = 21; id_funct = 6'b101010; id_mem_write = 0;
    id_mem_to_reg = 1;
    sb.push_back(mk(1, 4'b0111, 32'h77, 32'h88, 32'h88, 21,
                    1, 0, 0, 1, 0));
    @(posedge clk); #1;
    e = sb.pop_front(); o = obs(); checks++;
    if (o !== e) begin
      failures++;
      $display("FAIL stall_release got=%h exp=%h", o, e);
    end
  endtask

  task automatic test_illegal();
    clear_id();
    id_valid = 1; id_rs_val = 32'h33; id_rt_val = 32'h44;
    id_alu_op = 2'b10; id_funct = 6'b000111;
    id_reg_dst = 1; id_rd = 6; id_reg_write = 1;
    id_mem_write = 1; id_mem_read = 1;
    sb.push_back(mk(1, 4'b1111, 32'h33, 32'h44, 32'h44, 6,
                    0, 1, 0, 0, 1));
    @(posedge clk); #1;
    e = sb.pop_front(); o = obs(); checks++;
    if (o !== e) begin
      failures++;
      $display("FAIL illegal got=%h exp=%h", o, e);
    end
    id_valid = 0; id_mem_to_reg = 1;
    @(posedge clk); #1;
    checks++;
    if ({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write,
         ex_mem_to_reg, ex_illegal} !== 6'b0) begin
      failures++;
      $display("FAIL invalid_ctrl got=%b exp=000000",
               {ex_valid, ex_reg_write, ex_mem_read,
                ex_mem_write, ex_mem_to_reg, ex_illegal});
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    clear_id();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    test_reset();
    test_rtype();
    test_imm();
    test_forward();
    test_fwd_disabled();
    test_stall();
    test_illegal();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
